// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the RISC CPU datapath.
// Each state lasts one clock. T0-T2 fetch the instruction and T3-T7 execute it.
// The opcode is taken from ir[31:27], and the datapath control strobes are Moore
// outputs decoded from the state and the opcode.
//
// Ports:
//   clock          rising-edge clock
//   clear          asynchronous active-low reset; forces every strobe low while asserted
//   ir             instruction register contents (IR is stable from T3 onward)
//   pco..baout     datapath control strobes
//   alu_op         ALU operation; valid whenever rzli=1 (incpc overrides it in T0)
//   run            1 while executing, 0 in HALT
//   illegal        latched illegal-opcode flag
//
// Optional feature: define CU_ILLEGAL_TRAP_EN to make an undefined opcode set illegal
// and enter HALT. Without it, an undefined opcode executes as nop and illegal is tied to 0.
module control_sequencer #(
    parameter int unsigned OPC_W   = 5,
    parameter int unsigned STATE_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      ir,
    output logic             pco,
    output logic             pci,
    output logic             incpc,
    output logic             iri,
    output logic             mari,
    output logic             mdri,
    output logic             mdro,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ryi,
    output logic             rzli,
    output logic             rzlo,
    output logic             csigno,
    output logic             hio,
    output logic             loo,
    output logic             ipo,
    output logic             opi,
    output logic             gra,
    output logic             grb,
    output logic             grc,
    output logic             rin,
    output logic             rout,
    output logic             baout,
    output logic [OPC_W-1:0] alu_op,
    output logic             run,
    output logic             illegal
);

    localparam logic [STATE_W-1:0] T0   = 4'd0;
    localparam logic [STATE_W-1:0] T1   = 4'd1;
    localparam logic [STATE_W-1:0] T2   = 4'd2;
    localparam logic [STATE_W-1:0] T3   = 4'd3;
    localparam logic [STATE_W-1:0] T4   = 4'd4;
    localparam logic [STATE_W-1:0] T5   = 4'd5;
    localparam logic [STATE_W-1:0] T6   = 4'd6;
    localparam logic [STATE_W-1:0] T7   = 4'd7;
    localparam logic [STATE_W-1:0] HALT = 4'd8;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    logic [STATE_W-1:0] state_q, state_d;
    logic [OPC_W-1:0]   op;
    logic               is_rr, is_imm, is_addr, is_ld, is_mem;
    logic               unused_ir;

    assign op        = ir[31 -: OPC_W];
    assign unused_ir = ^ir[31-OPC_W:0];

    assign is_rr   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_imm  = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    assign is_ld   = (op == OP_LD);
    assign is_mem  = is_ld || (op == OP_ST);
    // ldi, ld and st share the base+offset address computation in T3-T4.
    assign is_addr = is_mem || (op == OP_LDI);

`ifdef CU_ILLEGAL_TRAP_EN
    logic legal;
    logic illegal_q, illegal_d;

    assign legal = is_rr || is_imm || is_addr || (op == OP_JR) || (op == OP_IN) ||
                   (op == OP_OUT) || (op == OP_MFHI) || (op == OP_MFLO) ||
                   (op == 5'b11010) || (op == OP_HALT);

    always_comb begin
        illegal_d = illegal_q;
        if (state_q == T3 && !legal) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            T0: state_d = T1;
            T1: state_d = T2;
            T2: state_d = T3;
            T3: begin
                if (op == OP_HALT) begin
                    state_d = HALT;
`ifdef CU_ILLEGAL_TRAP_EN
                end else if (!legal) begin
                    state_d = HALT;
`endif
                end else if (is_rr || is_imm || is_addr) begin
                    state_d = T4;
                end else begin
                    state_d = T0;
                end
            end
            T4:      state_d = T5;
            T5:      state_d = is_mem ? T6 : T0;
            T6:      state_d = T7;
            T7:      state_d = T0;
            HALT:    state_d = HALT;
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    assign run = (state_q != HALT);

    always_comb begin
        pco = 1'b0; pci = 1'b0; incpc = 1'b0; iri = 1'b0; mari = 1'b0;
        mdri = 1'b0; mdro = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        ryi = 1'b0; rzli = 1'b0; rzlo = 1'b0; csigno = 1'b0; hio = 1'b0;
        loo = 1'b0; ipo = 1'b0; opi = 1'b0; gra = 1'b0; grb = 1'b0;
        grc = 1'b0; rin = 1'b0; rout = 1'b0; baout = 1'b0;
        alu_op = '0;
        // Strobes are held low for as long as clear is asserted, even though state reads T0.
        if (clear) begin
            case (state_q)
                T0: begin pco = 1'b1; mari = 1'b1; incpc = 1'b1; rzli = 1'b1; end
                T1: begin rzlo = 1'b1; pci = 1'b1; mem_read = 1'b1; mdri = 1'b1; end
                T2: begin mdro = 1'b1; iri = 1'b1; end
                T3: begin
                    if (is_rr || is_imm) begin
                        grb = 1'b1; rout = 1'b1; ryi = 1'b1;
                    end else if (is_addr) begin
                        grb = 1'b1; baout = 1'b1; ryi = 1'b1;
                    end else begin
                        case (op)
                            OP_JR:   begin gra = 1'b1; rout = 1'b1; pci = 1'b1; end
                            OP_IN:   begin ipo = 1'b1; gra = 1'b1; rin = 1'b1; end
                            OP_OUT:  begin gra = 1'b1; rout = 1'b1; opi = 1'b1; end
                            OP_MFHI: begin hio = 1'b1; gra = 1'b1; rin = 1'b1; end
                            OP_MFLO: begin loo = 1'b1; gra = 1'b1; rin = 1'b1; end
                            default: ;
                        endcase
                    end
                end
                T4: begin
                    rzli = 1'b1;
                    if (is_rr) begin
                        grc = 1'b1; rout = 1'b1; alu_op = op;
                    end else if (is_imm) begin
                        csigno = 1'b1; alu_op = op;
                    end else begin
                        csigno = 1'b1; alu_op = OP_ADD;
                    end
                end
                T5: begin
                    rzlo = 1'b1;
                    if (is_mem) begin
                        mari = 1'b1;
                    end else begin
                        gra = 1'b1; rin = 1'b1;
                    end
                end
                T6: begin
                    mdri = 1'b1;
                    if (is_ld) begin
                        mem_read = 1'b1;
                    end else begin
                        gra = 1'b1; rout = 1'b1;
                    end
                end
                T7: begin
                    if (is_ld) begin
                        mdro = 1'b1; gra = 1'b1; rin = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
